// File: rtl/tug_pkg.sv
// ============================================================================
// Module : tug_pkg
// Brief  : Shared types and constants for the tug-of-war referee and scorer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tug_pkg;

    typedef enum logic [2:0] {
        DARK    = 3'd0,
        LIGHT   = 3'd1,
        REPORT  = 3'd2,
        RELEASE = 3'd3,
        OVER    = 3'd4
    } tug_state_e;

    // Score words (L3 L2 L1 N R1 R2 R3) that end a game.
    localparam logic [6:0] SCORE_WL = 7'b1110000;
    localparam logic [6:0] SCORE_WR = 7'b0000111;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    function automatic logic is_game_over(input logic [6:0] sc);
        return (sc == SCORE_WL) || (sc == SCORE_WR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tug_referee_push_sync.sv
// ============================================================================
// Module : push_sync
// Brief  : Two-flop synchronizer with rising-edge detect for one pushbutton.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module push_sync (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic level,
    output logic press
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = pb;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign level = sync2_q;
    assign press = sync2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/tug_referee.sv
// ============================================================================
// Module : tug_referee
// Brief  : Round controller: times the start light, judges the first push,
//          and stops play once the score word shows a won game.
//          Optional macro TUG_RANDOM_DELAY_EN adds an LFSR-random dark period.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tug_referee
    import tug_pkg::*;
#(
    parameter int          MIN_DLY = 1000,
    parameter int          DLY_W   = 8,
    parameter int          ON_CYC  = 5000,
    parameter int          HOLDOFF = 16,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_l,
    input  logic       pb_r,
    input  logic [6:0] score,
    output logic       winrnd,
    output logic       right,
    output logic       leds_on
);

    localparam int MAX_DARK = MIN_DLY + (1 << DLY_W) - 1;
    localparam int MAX_LOAD = (MAX_DARK > ON_CYC) ? MAX_DARK : ON_CYC;
    localparam int CNT_W    = $clog2(MAX_LOAD + 1);
    localparam int HOLD_W   = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    logic level_l, press_l, level_r, press_r;
    logic game_over;

    push_sync u_sync_l (.clk(clk), .rst(rst), .pb(pb_l), .level(level_l), .press(press_l));
    push_sync u_sync_r (.clk(clk), .rst(rst), .pb(pb_r), .level(level_r), .press(press_r));

    assign game_over = is_game_over(score);

    logic [CNT_W-1:0] dark_reload;

`ifdef TUG_RANDOM_DELAY_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lfsr_q <= SEED;
        else      lfsr_q <= lfsr_d;
    end

    assign dark_reload = CNT_W'(MIN_DLY) + CNT_W'(lfsr_q[DLY_W-1:0]);
`else
    logic unused_seed;
    assign unused_seed = ^SEED;
    assign dark_reload = CNT_W'(MIN_DLY);
`endif

    tug_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              right_q, right_d;
    logic              lit_q, lit_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        right_d = right_q;
        lit_d   = lit_q;
        winrnd  = 1'b0;
        leds_on = 1'b0;

        case (state_q)
            DARK: begin
                if (press_l ^ press_r) begin
                    right_d = press_r;
                    lit_d   = 1'b0;
                    state_d = REPORT;
                end else if (press_l & press_r) begin
                    hold_d  = '0;
                    state_d = RELEASE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = CNT_W'(ON_CYC);
                    state_d = LIGHT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LIGHT: begin
                leds_on = 1'b1;
                if (press_l ^ press_r) begin
                    right_d = press_r;
                    lit_d   = 1'b1;
                    state_d = REPORT;
                end else if ((press_l & press_r) || (cnt_q <= CNT_W'(1))) begin
                    hold_d  = '0;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REPORT: begin
                winrnd  = 1'b1;
                leds_on = lit_q;
                hold_d  = '0;
                state_d = game_over ? OVER : RELEASE;
            end
            RELEASE: begin
                if (level_l | level_r) begin
                    hold_d = '0;
                end else if (hold_q >= HOLD_W'(HOLDOFF - 1)) begin
                    cnt_d   = dark_reload;
                    state_d = DARK;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                cnt_d   = CNT_W'(MIN_DLY);
                state_d = DARK;
            end
        endcase

        // The report pulse always completes; REPORT handles game-over itself.
        if (game_over && (state_q != REPORT)) begin
            state_d = OVER;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DARK;
            cnt_q   <= CNT_W'(MIN_DLY);
            hold_q  <= '0;
            right_q <= 1'b0;
            lit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            right_q <= right_d;
            lit_q   <= lit_d;
        end
    end

    assign right = right_q;

endmodule

`default_nettype wire
